// File: rtl/pll_reconfig_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reconfig_ctrl
//  Description : Runtime reprogramming sequencer for the core Cyclone V PLL.
//                Writes one of two counter profiles into the Altera PLL
//                reconfiguration block over its Avalon-MM management port
//                (waitrequest mode), starts the reconfiguration, then waits
//                for the PLL to relock and reports done or timeout.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    refclk           in   controller clock (PLL reference clock)
//    rst              in   asynchronous active-high reset
//    req              in   level-sampled reconfiguration request (IDLE only)
//    prof_sel         in   profile to load, sampled together with req
//    busy             out  high from request acceptance until done or err
//    done             out  one-cycle pulse on successful relock
//    err              out  sticky relock timeout, cleared on next accept
//    cur_prof         out  last successfully loaded profile
//    mgmt_address     out  reconfig register address
//    mgmt_writedata   out  reconfig write data
//    mgmt_write       out  write strobe
//    mgmt_read        out  read strobe, never used (tied 0)
//    mgmt_waitrequest in   stall from the reconfig block
//    pll_locked       in   PLL lock indicator (asynchronous)
// ============================================================================
module pll_reconfig_ctrl #(
    // Profile packing, MSB first: {C3, C2, C1, C0, N, M}, 18 bits each,
    // each word = {odd_en, bypass, hi[7:0], lo[7:0]}.
    parameter logic [107:0] PROF0        = {18'h04848, 18'h04848, 18'h00909,
                                            18'h20504, 18'h20605, 18'h04040},
    parameter logic [107:0] PROF1        = {18'h04848, 18'h04848, 18'h00909,
                                            18'h20504, 18'h20605, 18'h04141},
    parameter int           LOCK_BLANK   = 16,
    parameter int           LOCK_TIMEOUT = 1048576
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        req,
    input  logic        prof_sel,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cur_prof,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        mgmt_write,
    output logic        mgmt_read,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked
);

    localparam int c_blank_w = (LOCK_BLANK   > 1) ? $clog2(LOCK_BLANK)   : 1;
    localparam int c_tmo_w   = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    localparam logic [c_blank_w-1:0] c_blank_last = c_blank_w'(LOCK_BLANK - 1);
    localparam logic [c_tmo_w-1:0]   c_tmo_last   = c_tmo_w'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WR         = 3'd1,
        ST_GAP        = 3'd2,
        ST_WAIT_BLANK = 3'd3,
        ST_WAIT_LOCK  = 3'd4
    } state_t;

    state_t                 state_q,     state_d;
    logic [2:0]             k_q,         k_d;
    logic                   prof_q,      prof_d;
    logic                   busy_q,      busy_d;
    logic                   done_q,      done_d;
    logic                   err_q,       err_d;
    logic                   cur_prof_q,  cur_prof_d;
    logic [c_blank_w-1:0]   blank_cnt_q, blank_cnt_d;
    logic [c_tmo_w-1:0]     tmo_cnt_q,   tmo_cnt_d;
    logic                   lock_s1_q,   lock_s1_d;
    logic                   lock_s2_q,   lock_s2_d;

    logic [107:0]           w_prof;
    logic [17:0]            w_word;
    logic [2:0]             w_cnt_sel;
    logic [5:0]             w_addr;
    logic [31:0]            w_data;

    // ------------------------------------------------------------------------
    // Write list decode: address and data for write index k
    // ------------------------------------------------------------------------
    assign w_prof    = prof_q ? PROF1 : PROF0;
    // C0..C3 are written with k = 3..6, so the counter select is k - 3.
    assign w_cnt_sel = k_q - 3'd3;

    always_comb begin
        w_word = 18'd0;
        case (k_q)
            3'd1:    w_word = w_prof[17:0];     // M
            3'd2:    w_word = w_prof[35:18];    // N
            3'd3:    w_word = w_prof[53:36];    // C0
            3'd4:    w_word = w_prof[71:54];    // C1
            3'd5:    w_word = w_prof[89:72];    // C2
            3'd6:    w_word = w_prof[107:90];   // C3
            default: w_word = 18'd0;
        endcase
    end

    always_comb begin
        w_addr = 6'd0;
        w_data = 32'd0;
        case (k_q)
            3'd0: begin                         // MODE = waitrequest mode
                w_addr = 6'd0;
                w_data = 32'd0;
            end
            3'd1: begin
                w_addr = 6'd4;
                w_data = {14'd0, w_word};
            end
            3'd2: begin
                w_addr = 6'd3;
                w_data = {14'd0, w_word};
            end
            3'd3, 3'd4, 3'd5, 3'd6: begin
                w_addr = 6'd5;
                w_data = {9'd0, 2'b00, w_cnt_sel, w_word};
            end
            default: begin                      // START
                w_addr = 6'd2;
                w_data = 32'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        prof_d      = prof_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        cur_prof_d  = cur_prof_q;
        blank_cnt_d = blank_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        lock_s1_d   = pll_locked;
        lock_s2_d   = lock_s1_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    prof_d  = prof_sel;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    k_d     = 3'd0;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                // Stall indefinitely while the reconfig block holds off.
                if (!mgmt_waitrequest) begin
                    if (k_q == 3'd7) begin
                        blank_cnt_d = '0;
                        state_d     = ST_WAIT_BLANK;
                    end else begin
                        state_d     = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                k_d     = k_q + 3'd1;
                state_d = ST_WR;
            end
            ST_WAIT_BLANK: begin
                // Lock may still read high from the old configuration here.
                if (blank_cnt_q == c_blank_last) begin
                    tmo_cnt_d = '0;
                    state_d   = ST_WAIT_LOCK;
                end else begin
                    blank_cnt_d = blank_cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock is tested first so it wins over a coincident timeout.
                if (lock_s2_q) begin
                    done_d     = 1'b1;
                    cur_prof_d = prof_q;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end else if (tmo_cnt_q == c_tmo_last) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= 3'd0;
            prof_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cur_prof_q  <= 1'b0;
            blank_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            lock_s1_q   <= 1'b0;
            lock_s2_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            prof_q      <= prof_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cur_prof_q  <= cur_prof_d;
            blank_cnt_q <= blank_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            lock_s1_q   <= lock_s1_d;
            lock_s2_q   <= lock_s2_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: bus signals are only driven while a write is being issued.
    // ------------------------------------------------------------------------
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign cur_prof       = cur_prof_q;
    assign mgmt_write     = (state_q == ST_WR);
    assign mgmt_address   = (state_q == ST_WR) ? w_addr : 6'd0;
    assign mgmt_writedata = (state_q == ST_WR) ? w_data : 32'd0;
    assign mgmt_read      = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_pll_reconfig_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_reconfig_ctrl
//  Description : Self-checking bench for pll_reconfig_ctrl. Expected writes
//                are queued when a request is issued and compared as the
//                controller completes each Avalon write.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pll_reconfig_ctrl;

    logic        refclk = 1'b0;
    logic        rst;
    logic        req;
    logic        prof_sel;
    logic        busy;
    logic        done;
    logic        err;
    logic        cur_prof;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_write;
    logic        mgmt_read;
    logic        mgmt_waitrequest;
    logic        pll_locked;

    pll_reconfig_ctrl #(
        .LOCK_BLANK   (16),
        .LOCK_TIMEOUT (100)
    ) dut (
        .refclk           (refclk),
        .rst              (rst),
        .req              (req),
        .prof_sel         (prof_sel),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .cur_prof         (cur_prof),
        .mgmt_address     (mgmt_address),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_write       (mgmt_write),
        .mgmt_read        (mgmt_read),
        .mgmt_waitrequest (mgmt_waitrequest),
        .pll_locked       (pll_locked)
    );

    always #5 refclk = ~refclk;

    int cyc = 0;
    always @(posedge refclk) cyc <= cyc + 1;

    int           checks = 0;
    int           errors = 0;
    logic [37:0]  exp_q[$];
    int           wr_cnt    = 0;
    int           stall_cnt = 0;
    int           done_cnt  = 0;
    int           done_cyc  = 0;
    int           acc_cyc[16];
    logic         stall_prev = 1'b0;
    logic         done_prev  = 1'b0;
    logic [5:0]   held_addr  = 6'd0;
    logic [31:0]  held_data  = 32'd0;

    // Expected {address, data} of write k for profile p.
    function automatic logic [37:0] exp_wr(input logic p, input int k);
        logic [17:0] m;
        m = p ? 18'h04141 : 18'h04040;
        case (k)
            0:       return {6'd0, 32'd0};
            1:       return {6'd4, 14'd0, m};
            2:       return {6'd3, 14'd0, 18'h20605};
            3:       return {6'd5, 9'd0, 5'd0, 18'h20504};
            4:       return {6'd5, 9'd0, 5'd1, 18'h00909};
            5:       return {6'd5, 9'd0, 5'd2, 18'h04848};
            6:       return {6'd5, 9'd0, 5'd3, 18'h04848};
            default: return {6'd2, 32'd0};
        endcase
    endfunction

    // Bus monitor and scoreboard, sampled on the falling edge.
    always @(negedge refclk) begin
        logic [37:0] e;
        if (rst) begin
            stall_prev = 1'b0;
            done_prev  = 1'b0;
        end else begin
            if (mgmt_write && mgmt_waitrequest) begin
                if (stall_prev) begin
                    checks++;
                    if ({mgmt_address, mgmt_writedata} !== {held_addr, held_data}) begin
                        errors++;
                        $display("FAIL stall_stable: got addr=%0d data=%h, held addr=%0d data=%h",
                                 mgmt_address, mgmt_writedata, held_addr, held_data);
                    end
                end
                held_addr  = mgmt_address;
                held_data  = mgmt_writedata;
                stall_prev = 1'b1;
                stall_cnt++;
            end else if (mgmt_write) begin
                if (stall_prev) begin
                    checks++;
                    if ({mgmt_address, mgmt_writedata} !== {held_addr, held_data}) begin
                        errors++;
                        $display("FAIL stall_release: got addr=%0d data=%h, held addr=%0d data=%h",
                                 mgmt_address, mgmt_writedata, held_addr, held_data);
                    end
                end
                stall_prev = 1'b0;
                if (wr_cnt < 16) acc_cyc[wr_cnt] = cyc;
                wr_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr=%0d data=%h, expected none",
                             mgmt_address, mgmt_writedata);
                end else begin
                    e = exp_q.pop_front();
                    if ({mgmt_address, mgmt_writedata} !== e) begin
                        errors++;
                        $display("FAIL write_content: got addr=%0d data=%h, expected addr=%0d data=%h",
                                 mgmt_address, mgmt_writedata, e[37:32], e[31:0]);
                    end
                end
            end else begin
                stall_prev = 1'b0;
            end
            if (done) begin
                checks++;
                if (done_prev) begin
                    errors++;
                    $display("FAIL done_width: got done high 2 cycles, expected 1");
                end
                done_cnt++;
                done_cyc = cyc;
            end
            done_prev = done;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    // Issues a one-cycle request; t is the cycle in which req is sampled.
    task automatic start_req(input logic p, output int t);
        prof_sel = p;
        req      = 1'b1;
        t        = cyc;
        for (int k = 0; k < 8; k++) exp_q.push_back(exp_wr(p, k));
        tick(1);
        req = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int max_cyc);
        int n;
        n = 0;
        while (done_cnt == prev && n < max_cyc) begin
            tick(1);
            n++;
        end
        checks++;
        if (done_cnt == prev) begin
            errors++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected a pulse", max_cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; prof_sel = 1'b0;
        mgmt_waitrequest = 1'b0; pll_locked = 1'b0;
        tick(3);
        checks++;
        if ({busy, done, err, cur_prof, mgmt_write, mgmt_read, mgmt_address, mgmt_writedata} !== 42'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b cur=%b wr=%b rd=%b addr=%0d data=%h, expected all 0",
                     busy, done, err, cur_prof, mgmt_write, mgmt_read, mgmt_address, mgmt_writedata);
        end
        rst = 1'b0;
        tick(3);
        checks++;
        if (busy !== 1'b0 || mgmt_write !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet: got busy=%b wr=%b, expected 0 0", busy, mgmt_write);
        end
    endtask

    task automatic test_basic();
        int t, d0;
        wr_cnt = 0; d0 = done_cnt;
        start_req(1'b1, t);
        checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: got busy=%b err=%b, expected 1 0", busy, err);
        end
        wait_until(t + 55);           // 40 cycles after START completes
        pll_locked = 1'b1;
        wait_done(d0, 100);
        checks++;
        if (wr_cnt !== 8) begin
            errors++;
            $display("FAIL basic_wr_count: got %0d, expected 8", wr_cnt);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (acc_cyc[k] !== t + 1 + 2 * k) begin
                errors++;
                $display("FAIL basic_wr_timing: write %0d at cycle %0d, expected %0d", k, acc_cyc[k], t + 1 + 2 * k);
            end
        end
        checks++;
        if (done_cyc !== t + 58) begin
            errors++;
            $display("FAIL basic_done_cycle: got %0d, expected %0d", done_cyc, t + 58);
        end
        checks++;
        if (cur_prof !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL basic_status: got cur=%b busy=%b err=%b, expected 1 0 0", cur_prof, busy, err);
        end
        tick(3);
        checks++;
        if (done_cnt !== d0 + 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_done_count: got %0d pulses, %0d pending writes, expected 1 and 0",
                     done_cnt - d0, exp_q.size());
        end
        pll_locked = 1'b0;
        tick(5);
    endtask

    task automatic test_waitrequest();
        int t, d0;
        wr_cnt = 0; stall_cnt = 0; d0 = done_cnt;
        start_req(1'b1, t);
        wait_until(t + 15);           // START is presented in this cycle
        mgmt_waitrequest = 1'b1;
        wait_until(t + 20);
        mgmt_waitrequest = 1'b0;
        wait_until(t + 21);
        pll_locked = 1'b1;
        wait_done(d0, 100);
        checks++;
        if (stall_cnt !== 5) begin
            errors++;
            $display("FAIL wreq_stall_count: got %0d, expected 5", stall_cnt);
        end
        checks++;
        if (wr_cnt !== 8 || acc_cyc[7] !== t + 20) begin
            errors++;
            $display("FAIL wreq_start_accept: got %0d writes, START at %0d, expected 8 at %0d",
                     wr_cnt, acc_cyc[7], t + 20);
        end
        checks++;
        if (done_cyc !== t + 38) begin
            errors++;
            $display("FAIL wreq_done_cycle: got %0d, expected %0d", done_cyc, t + 38);
        end
        pll_locked = 1'b0;
        tick(5);
    endtask

    task automatic test_stale_lock();
        int t, d0;
        pll_locked = 1'b1;
        tick(4);
        wr_cnt = 0; d0 = done_cnt;
        start_req(1'b0, t);
        wait_done(d0, 100);
        checks++;
        if (done_cyc !== t + 33) begin
            errors++;
            $display("FAIL stale_done_cycle: got %0d, expected %0d", done_cyc, t + 33);
        end
        checks++;
        if (cur_prof !== 1'b0 || wr_cnt !== 8) begin
            errors++;
            $display("FAIL stale_status: got cur=%b writes=%0d, expected 0 8", cur_prof, wr_cnt);
        end
        pll_locked = 1'b0;
        tick(5);
    endtask

    task automatic test_timeout();
        int t, d0;
        wr_cnt = 0; d0 = done_cnt;
        start_req(1'b1, t);
        wait_until(t + 131);          // last WAIT_LOCK cycle (counter = 99)
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL tmo_early: got err=%b busy=%b, expected 0 1", err, busy);
        end
        tick(1);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_flag: got err=%b busy=%b, expected 1 0", err, busy);
        end
        checks++;
        if (done_cnt !== d0 || cur_prof !== 1'b0 || wr_cnt !== 8) begin
            errors++;
            $display("FAIL tmo_status: got done=%0d cur=%b writes=%0d, expected 0 0 8",
                     done_cnt - d0, cur_prof, wr_cnt);
        end
        tick(3);
    endtask

    task automatic test_back_to_back();
        int t, d0;
        wr_cnt = 0; d0 = done_cnt;
        start_req(1'b1, t);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_err_clear: got err=%b, expected 0", err);
        end
        wait_until(t + 5);
        prof_sel = 1'b0;
        req      = 1'b1;
        tick(1);
        req      = 1'b0;
        wait_until(t + 16);
        pll_locked = 1'b1;
        wait_done(d0, 100);
        tick(20);
        checks++;
        if (wr_cnt !== 8 || busy !== 1'b0 || done_cnt !== d0 + 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_ignored: got writes=%0d busy=%b done=%0d pending=%0d, expected 8 0 1 0",
                     wr_cnt, busy, done_cnt - d0, exp_q.size());
        end
        checks++;
        if (cur_prof !== 1'b1) begin
            errors++;
            $display("FAIL b2b_profile: got cur=%b, expected 1", cur_prof);
        end
        pll_locked = 1'b0;
        tick(5);
    endtask

    task automatic test_reset_mid();
        int t, t2, d0;
        wr_cnt = 0;
        start_req(1'b1, t);
        wait_until(t + 7);            // write k=3 presented
        checks++;
        if (mgmt_write !== 1'b1 || mgmt_address !== 6'd5) begin
            errors++;
            $display("FAIL mid_k3: got wr=%b addr=%0d, expected 1 5", mgmt_write, mgmt_address);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, err, cur_prof, mgmt_write, mgmt_read, mgmt_address, mgmt_writedata} !== 42'd0) begin
            errors++;
            $display("FAIL mid_async_reset: got busy=%b done=%b err=%b cur=%b wr=%b rd=%b addr=%0d data=%h, expected all 0",
                     busy, done, err, cur_prof, mgmt_write, mgmt_read, mgmt_address, mgmt_writedata);
        end
        exp_q.delete();
        tick(2);
        rst = 1'b0;
        tick(2);
        wr_cnt = 0; d0 = done_cnt;
        start_req(1'b0, t2);
        wait_until(t2 + 16);
        pll_locked = 1'b1;
        wait_done(d0, 100);
        checks++;
        if (wr_cnt !== 8 || acc_cyc[0] !== t2 + 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_restart: got writes=%0d first at %0d pending=%0d, expected 8 at %0d 0",
                     wr_cnt, acc_cyc[0], exp_q.size(), t2 + 1);
        end
        pll_locked = 1'b0;
        tick(5);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_waitrequest();
        test_stale_lock();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
- Sequences runtime reprogramming of the core Cyclone V PLL through the Altera PLL reconfiguration block's Avalon-MM management port (waitrequest mode).
- Switches the PLL between two counter profiles, for example native arcade timing and an alternate video/refresh timing, on a single request.
- Waits for relock and reports done or timeout.
- Sits between core/menu control logic and the reconfig block that drives the PLL's reconfig_to_pll/reconfig_from_pll buses.

Parameters:
- PROF0, 108'h{...}: six packed 18-bit counter words {C3,C2,C1,C0,N,M}, MSB first; each word is {odd_en[17], bypass[16], hi[15:8], lo[7:0]}. Default: M=18'h04040, N=18'h20605, C0=18'h20504, C1=18'h00909, C2=18'h04848, C3=18'h04848.
- PROF1, 108'h{...}: alternate profile, same packing. Default: M=18'h04141, other words equal to PROF0.
- LOCK_BLANK, 16: refclk cycles after the START write during which pll_locked is ignored.
- LOCK_TIMEOUT, 1048576: refclk cycles allowed in WAIT_LOCK before an error is flagged.

Ports:
- refclk, in, 1: controller clock (the same 74.25 MHz reference that feeds the PLL).
- rst, in, 1: asynchronous, active-high reset.
- req, in, 1: level-sampled reconfiguration request.
- prof_sel, in, 1: profile to load; sampled with req.
- busy, out, 1: high from acceptance until done or error.
- done, out, 1: one-cycle pulse on successful relock.
- err, out, 1: sticky timeout flag; cleared when the next request is accepted.
- cur_prof, out, 1: last successfully loaded profile.
- mgmt_address, out, 6: reconfig register address.
- mgmt_writedata, out, 32: reconfig write data.
- mgmt_write, out, 1: write strobe.
- mgmt_read, out, 1: tied 0.
- mgmt_waitrequest, in, 1: stall from the reconfig block.
- pll_locked, in, 1: PLL locked output.

Behaviour:
- Reset values: busy=0, done=0, err=0, cur_prof=0, mgmt_write=0, mgmt_address=0, mgmt_writedata=0, state=IDLE. An asserted rst aborts any sequence immediately. A partially written PLL is then left as is; no recovery write is issued.
- States: IDLE, WR (write issue), GAP, WAIT_BLANK, WAIT_LOCK.
- IDLE:
  - When req=1, latch prof_sel, clear err, set busy=1, load write index k=0, and go to WR.
  - req while busy is ignored and is not queued.
- Write list, fixed order, k=0..7:
  - k=0: addr 0, data 0 (MODE = waitrequest mode).
  - k=1: addr 4, data M.
  - k=2: addr 3, data N.
  - k=3..6: addr 5, data {9'b0, cnt_sel[4:0]=k-3, word}, using word C0..C3.
  - k=7: addr 2, data 0 (START).
  - All data is zero-extended to 32 bits.
- WR:
  - Hold mgmt_write=1 with stable address and data until a cycle with mgmt_waitrequest=0. That edge completes the write.
  - Then go to GAP, or to WAIT_BLANK if k=7.
  - A waitrequest held for any length simply stalls the controller; there is no timeout on writes.
- GAP: one cycle with mgmt_write=0, then k=k+1 and back to WR.
- Latency with waitrequest tied 0 and req seen in IDLE at cycle T:
  - Write k is presented at cycle T+1+2k.
  - START completes at T+15.
  - WAIT_BLANK is entered at T+16.
- WAIT_BLANK: count LOCK_BLANK cycles with pll_locked ignored, then go to WAIT_LOCK.
- WAIT_LOCK:
  - The timeout counter starts at 0 on entry.
  - First cycle with pll_locked=1: next cycle done=1 (one cycle), cur_prof=latched profile, busy=0, state IDLE.
  - If the counter reaches LOCK_TIMEOUT-1 without lock: err=1, busy=0, cur_prof unchanged, no done pulse, state IDLE.
  - If lock and timeout occur in the same cycle, lock wins.
- req=1 held continuously restarts a new sequence on the cycle after returning to IDLE. Callers must drop req after busy rises.
- pll_locked is an asynchronous input: it passes through a 2-flop synchronizer, which adds 2 cycles to lock detection.
- Counter widths: k is 3 bits; the blank and timeout counters are sized by $clog2 of their parameters.

Test Plan:
- Reset, then req=1/prof_sel=1 for 1 cycle, waitrequest=0, locked rises 40 cycles after START → exactly 8 writes with addr sequence 0,4,3,5,5,5,5,2; C writes carry cnt_sel 0..3 in data[22:18]; M write data=32'h00004141; done pulses once; cur_prof=1; busy low after done.
- Same request with waitrequest held high 5 cycles on the START write → address and data stable for all 6 cycles; write accepted exactly once; sequence resumes.
- locked never rises, LOCK_TIMEOUT=100 → err=1 and busy=0 at blank+sync+100 cycles; no done; cur_prof unchanged at 0.
- pll_locked stays 1 throughout the blank window (stale lock) → not accepted before LOCK_BLANK expires; done at the first post-blank synchronized lock.
- Second req pulsed while busy → ignored; total write count stays 8.
- rst asserted mid-sequence at write k=3 → all outputs return to reset values asynchronously; a new req after release restarts from k=0.
